serial_sub_ctrl: RTL

- Bit-serial subtraction controller for WIDTH-bit operands. It time-shares one full-subtractor cell across all bit positions.
- Sequences LSB-first, one bit per clock, and holds the running borrow in a flop.
- Uses a valid/ready handshake on both the operand side and the result side.
- Sits between a register-file/ALU front end and any consumer that needs area-cheap subtraction.

---
 rtl/serial_sub_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial WIDTH-bit subtractor, LSB-first, valid/ready on both sides
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             dbit_d;
    logic             borrow_d;
    logic [WIDTH-1:0] a_d;
    logic             last_bit;

    // Single full-subtractor cell shared by all bit positions.
    always_comb begin
        dbit_d   = a_q[0] ^ b_q[0] ^ borrow_q;
        borrow_d = (~a_q[0] & (b_q[0] ^ borrow_q)) | (b_q[0] & borrow_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Difference bits fill the minuend register from the MSB side as it drains.
    generate
        if (WIDTH == 1) begin : g_w1
            assign a_d = dbit_d;
        end else begin : g_wn
            assign a_d = {dbit_d, a_q[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        borrow_q   <= bin;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q    <= a[WIDTH-1];
                        b_msb_q    <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_q      <= a_d;
                    b_q      <= b_q >> 1;
                    borrow_q <= borrow_d;
                    if (last_bit) begin
                        diff_q      <= a_d;
                        bout_q      <= borrow_d;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q       <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ dbit_d);
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
